// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller with load-use detection and multi-cycle EX sequencing
module pipe_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_read,
  input  logic       id_rt_read,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wr_address,
  input  logic       ex_mc_start,
  input  logic       ex_mc_is_div,
  input  logic       flush_req,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic       mc_busy,
  output logic       mc_done
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [6:0] n;
  logic start, lu, mc;
  assign n = ex_mc_is_div ? 7'(DIV_CYCLES) : 7'(MUL_CYCLES);
  assign start = state == IDLE && ex_mc_start && !flush_req;
  assign lu = ex_is_load && ex_wr_address != 5'd0 &&
              ((id_rs_read && id_rs_addr == ex_wr_address) ||
               (id_rt_read && id_rt_addr == ex_wr_address));
  assign mc = mc_busy;
  assign mc_busy = state == BUSY || start;
  assign mc_done = state == DONE;
  assign stall_pc = !flush_req && (mc || lu);
  assign stall_ifid = !flush_req && (mc || lu);
  assign stall_idex = !flush_req && mc;
  assign stall_exmem = !flush_req && mc;
  assign flush_ifid = flush_req;
  assign flush_idex = flush_req || (!mc && lu);
  assign flush_exmem = flush_req || mc;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (flush_req) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (start) begin
      state_nxt = n >= 7'd2 ? BUSY : DONE;
      cnt_nxt = n >= 7'd2 ? 6'(n - 7'd2) : '0;
    end else if (state == BUSY) begin
      state_nxt = cnt == 6'd0 ? DONE : BUSY;
      cnt_nxt = cnt == 6'd0 ? '0 : cnt - 6'd1;
    end else if (state == DONE) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
endmodule
